// File: rtl/gmii_if.sv
`default_nettype none
// ============================================================================
// Module   : gmii_if
// Brief    : GMII receive byte stream, one byte per cycle with a valid strobe.
// Revision : 1.0 - initial release
// ============================================================================
interface gmii_if;
    logic       valid;
    logic [7:0] data;

    modport master (
        output valid,
        output data
    );

    modport slave (
        input valid,
        input data
    );
endinterface : gmii_if
`default_nettype wire

// File: rtl/rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rx_frame_ctrl
// Brief    : GMII RX frame sequencer: preamble/SFD delineation, CRC-checker
//            qualifier, length checks, per-frame status and frame counters.
// Revision : 1.0 - initial release
// ============================================================================
module rx_frame_ctrl #(
    parameter int MIN_PREAMBLE_BYTES = 1,
    parameter int MIN_FRAME_LEN      = 64,
    parameter int MAX_FRAME_LEN      = 1518,
    parameter int LEN_W              = 14,
    parameter int CNT_W              = 32
) (
    input  wire logic             clk,
    input  wire logic             rst,
    gmii_if.slave                 gmii_rx_if_i,
    input  wire logic             crc_error_i,
    output logic                  is_preamble_or_sfd_o,
    output logic                  frame_status_valid_o,
    output logic                  frame_good_o,
    output logic                  crc_err_o,
    output logic                  runt_o,
    output logic                  giant_o,
    output logic                  align_err_o,
    output logic [LEN_W-1:0]      frame_len_o,
    output logic [CNT_W-1:0]      good_frames_o,
    output logic [CNT_W-1:0]      bad_frames_o
);

    localparam logic [1:0]       c_S_IDLE     = 2'd0;
    localparam logic [1:0]       c_S_PREAMBLE = 2'd1;
    localparam logic [1:0]       c_S_FRAME    = 2'd2;
    localparam logic [1:0]       c_S_DROP     = 2'd3;

    localparam logic [7:0]       c_PRE_BYTE   = 8'h55;
    localparam logic [7:0]       c_SFD_BYTE   = 8'hD5;
    localparam logic [2:0]       c_PRE_MAX    = 3'd7;
    localparam logic [2:0]       c_PRE_MIN    = 3'(MIN_PREAMBLE_BYTES);
    localparam logic [LEN_W-1:0] c_LEN_MAX    = {LEN_W{1'b1}};

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [2:0]       r_pre_cnt;
    logic [2:0]       w_pre_cnt_nxt;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] w_len_nxt;

    logic             w_valid;
    logic [7:0]       w_data;
    logic             w_frame_end;
    logic             w_in_frame;
    logic [31:0]      w_len_ext;
    logic             w_crc;
    logic             w_runt;
    logic             w_giant;
    logic             w_align;
    logic             w_good;

    logic             r_status_valid;
    logic             r_frame_good;
    logic             r_crc_err;
    logic             r_runt;
    logic             r_giant;
    logic             r_align_err;
    logic [LEN_W-1:0] r_frame_len;
    logic [CNT_W-1:0] r_good_frames;
    logic [CNT_W-1:0] r_bad_frames;

    assign w_valid = gmii_rx_if_i.valid;
    assign w_data  = gmii_rx_if_i.data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_S_IDLE;
            r_pre_cnt <= 3'd0;
            r_len     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pre_cnt <= w_pre_cnt_nxt;
            r_len     <= w_len_nxt;
        end
    end

    // Every non-IDLE state returns to IDLE when valid drops; that cycle is the frame end.
    always_comb begin
        w_state_nxt   = r_state;
        w_pre_cnt_nxt = r_pre_cnt;
        w_len_nxt     = r_len;
        case (r_state)
            c_S_IDLE: begin
                if (w_valid) begin
                    if (w_data == c_PRE_BYTE) begin
                        w_state_nxt   = c_S_PREAMBLE;
                        w_pre_cnt_nxt = 3'd1;
                    end else begin
                        w_state_nxt   = c_S_DROP;
                    end
                end
            end
            c_S_PREAMBLE: begin
                if (!w_valid) begin
                    w_state_nxt = c_S_IDLE;
                end else if (w_data == c_PRE_BYTE) begin
                    if (r_pre_cnt != c_PRE_MAX) begin
                        w_pre_cnt_nxt = r_pre_cnt + 3'd1;
                    end
                end else if ((w_data == c_SFD_BYTE) && (r_pre_cnt >= c_PRE_MIN)) begin
                    w_state_nxt = c_S_FRAME;
                    w_len_nxt   = '0;
                end else begin
                    w_state_nxt = c_S_DROP;
                end
            end
            c_S_FRAME: begin
                if (!w_valid) begin
                    w_state_nxt = c_S_IDLE;
                end else if (r_len != c_LEN_MAX) begin
                    w_len_nxt = r_len + 1'b1;
                end
            end
            c_S_DROP: begin
                if (!w_valid) begin
                    w_state_nxt = c_S_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    assign w_frame_end = !w_valid && (r_state != c_S_IDLE);
    assign w_in_frame  = (r_state == c_S_FRAME);
    assign w_len_ext   = 32'(r_len);

    // Frames that never reached FRAME report only the alignment error.
    assign w_crc   = w_in_frame && crc_error_i;
    assign w_runt  = w_in_frame && (w_len_ext < 32'(MIN_FRAME_LEN));
    assign w_giant = w_in_frame && (w_len_ext > 32'(MAX_FRAME_LEN));
    assign w_align = !w_in_frame;
    assign w_good  = !(w_crc || w_runt || w_giant || w_align);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_status_valid <= 1'b0;
            r_frame_good   <= 1'b0;
            r_crc_err      <= 1'b0;
            r_runt         <= 1'b0;
            r_giant        <= 1'b0;
            r_align_err    <= 1'b0;
            r_frame_len    <= '0;
            r_good_frames  <= '0;
            r_bad_frames   <= '0;
        end else begin
            r_status_valid <= w_frame_end;
            if (w_frame_end) begin
                r_frame_good <= w_good;
                r_crc_err    <= w_crc;
                r_runt       <= w_runt;
                r_giant      <= w_giant;
                r_align_err  <= w_align;
                r_frame_len  <= w_in_frame ? r_len : '0;
                if (w_good) begin
                    r_good_frames <= r_good_frames + 1'b1;
                end else begin
                    r_bad_frames  <= r_bad_frames + 1'b1;
                end
            end
        end
    end

    assign is_preamble_or_sfd_o = (r_state != c_S_FRAME);
    assign frame_status_valid_o = r_status_valid;
    assign frame_good_o         = r_frame_good;
    assign crc_err_o            = r_crc_err;
    assign runt_o               = r_runt;
    assign giant_o              = r_giant;
    assign align_err_o          = r_align_err;
    assign frame_len_o          = r_frame_len;
    assign good_frames_o        = r_good_frames;
    assign bad_frames_o         = r_bad_frames;

endmodule : rx_frame_ctrl
`default_nettype wire

// File: tb/tb_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_frame_ctrl
// Brief    : Directed self-checking bench for rx_frame_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rx_frame_ctrl;

    localparam int LEN_W = 14;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             crc_error_i;
    logic             is_preamble_or_sfd_o;
    logic             frame_status_valid_o;
    logic             frame_good_o;
    logic             crc_err_o;
    logic             runt_o;
    logic             giant_o;
    logic             align_err_o;
    logic [LEN_W-1:0] frame_len_o;
    logic [CNT_W-1:0] good_frames_o;
    logic [CNT_W-1:0] bad_frames_o;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int pulse_cnt  = 0;
    int pulse_last = 0;
    int pulse_prev = 0;

    gmii_if gmii ();

    rx_frame_ctrl #(
        .MIN_PREAMBLE_BYTES (2),
        .MIN_FRAME_LEN      (64),
        .MAX_FRAME_LEN      (1518),
        .LEN_W              (LEN_W),
        .CNT_W              (CNT_W)
    ) u_dut (
        .clk                  (clk),
        .rst                  (rst),
        .gmii_rx_if_i         (gmii),
        .crc_error_i          (crc_error_i),
        .is_preamble_or_sfd_o (is_preamble_or_sfd_o),
        .frame_status_valid_o (frame_status_valid_o),
        .frame_good_o         (frame_good_o),
        .crc_err_o            (crc_err_o),
        .runt_o               (runt_o),
        .giant_o              (giant_o),
        .align_err_o          (align_err_o),
        .frame_len_o          (frame_len_o),
        .good_frames_o        (good_frames_o),
        .bad_frames_o         (bad_frames_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_status_valid_o) begin
            pulse_cnt  = pulse_cnt + 1;
            pulse_prev = pulse_last;
            pulse_last = cyc;
        end
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        gmii.valid = 1'b1;
        gmii.data  = b;
        step();
    endtask

    // Drives npre preamble bytes, one delimiter byte and nbytes body bytes.
    task automatic run_frame(input string tag, input int npre, input logic [7:0] sfd,
                             input int nbytes, input bit exp_frame);
        int qual_bad;
        qual_bad = 0;
        for (int i = 0; i < npre; i++) begin
            if (is_preamble_or_sfd_o !== 1'b1) qual_bad++;
            send_byte(8'h55);
        end
        if (is_preamble_or_sfd_o !== 1'b1) qual_bad++;
        send_byte(sfd);
        for (int i = 0; i < nbytes; i++) begin
            if (i == 0 && exp_frame) chk({tag, ".qual_first_da"}, is_preamble_or_sfd_o, 0);
            if (is_preamble_or_sfd_o !== !exp_frame) qual_bad++;
            send_byte(8'((i * 7 + 3) & 255));
        end
        chk({tag, ".qual_bad_cycles"}, qual_bad, 0);
    endtask

    task automatic end_frame(input string tag, input logic crc_in,
                             input logic e_crc, input logic e_runt, input logic e_giant,
                             input logic e_align, input int e_len,
                             input int e_good_cnt, input int e_bad_cnt, input bit hold);
        logic e_good;
        e_good = !(e_crc || e_runt || e_giant || e_align);
        gmii.valid  = 1'b0;
        crc_error_i = crc_in;
        chk({tag, ".pulse_at_E"}, frame_status_valid_o, 0);
        step();
        crc_error_i = 1'b0;
        chk({tag, ".pulse"},     frame_status_valid_o, 1);
        chk({tag, ".good"},      frame_good_o, e_good);
        chk({tag, ".crc_err"},   crc_err_o, e_crc);
        chk({tag, ".runt"},      runt_o, e_runt);
        chk({tag, ".giant"},     giant_o, e_giant);
        chk({tag, ".align"},     align_err_o, e_align);
        chk({tag, ".len"},       frame_len_o, e_len);
        chk({tag, ".good_cnt"},  good_frames_o, e_good_cnt);
        chk({tag, ".bad_cnt"},   bad_frames_o, e_bad_cnt);
        if (hold) begin
            step();
            chk({tag, ".pulse_end"}, frame_status_valid_o, 0);
            chk({tag, ".len_hold"},  frame_len_o, e_len);
            chk({tag, ".good_hold"}, frame_good_o, e_good);
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0;
        rst         = 1'b1;
        gmii.valid  = 1'b0;
        gmii.data   = 8'h00;
        crc_error_i = 1'b0;
        step();
        step();
        rst = 1'b0;

        chk("rst.pulse",    frame_status_valid_o, 0);
        chk("rst.qual",     is_preamble_or_sfd_o, 1);
        chk("rst.good",     frame_good_o, 0);
        chk("rst.align",    align_err_o, 0);
        chk("rst.len",      frame_len_o, 0);
        chk("rst.good_cnt", good_frames_o, 0);
        chk("rst.bad_cnt",  bad_frames_o, 0);

        for (int i = 0; i < 5; i++) step();
        chk("idle.no_pulse", pulse_cnt, 0);

        run_frame("good64", 7, 8'hD5, 64, 1);
        end_frame("good64", 0, 0, 0, 0, 0, 64, 1, 0, 1);

        run_frame("crc64", 7, 8'hD5, 64, 1);
        end_frame("crc64", 1, 1, 0, 0, 0, 64, 1, 1, 1);

        run_frame("runt60", 7, 8'hD5, 60, 1);
        end_frame("runt60", 0, 0, 1, 0, 0, 60, 1, 2, 1);

        run_frame("runt63", 7, 8'hD5, 63, 1);
        end_frame("runt63", 0, 0, 1, 0, 0, 63, 1, 3, 1);

        run_frame("giant1519", 7, 8'hD5, 1519, 1);
        end_frame("giant1519", 0, 0, 0, 1, 0, 1519, 1, 4, 1);

        run_frame("max1518", 7, 8'hD5, 1518, 1);
        end_frame("max1518", 0, 0, 0, 0, 0, 1518, 2, 4, 1);

        // Bad delimiter; a CRC flag from the checker must not leak into the status.
        run_frame("align", 2, 8'h13, 70, 0);
        end_frame("align", 1, 0, 0, 0, 1, 0, 2, 5, 1);

        run_frame("sfd_early", 1, 8'hD5, 70, 0);
        end_frame("sfd_early", 0, 0, 0, 0, 1, 0, 2, 6, 1);

        run_frame("min_pre", 2, 8'hD5, 64, 1);
        end_frame("min_pre", 0, 0, 0, 0, 0, 64, 3, 6, 1);

        run_frame("idle_sfd", 0, 8'hD5, 20, 0);
        end_frame("idle_sfd", 0, 0, 0, 0, 1, 0, 3, 7, 1);

        run_frame("b2b_a", 7, 8'hD5, 64, 1);
        end_frame("b2b_a", 0, 0, 0, 0, 0, 64, 4, 7, 0);
        run_frame("b2b_b", 7, 8'hD5, 64, 1);
        end_frame("b2b_b", 0, 0, 0, 0, 0, 64, 5, 7, 1);
        chk("b2b.pulse_gap", pulse_last - pulse_prev, 73);

        run_frame("sat", 7, 8'hD5, 16400, 1);
        end_frame("sat", 0, 0, 0, 1, 0, 16383, 5, 8, 1);

        run_frame("rst_mid", 7, 8'hD5, 30, 1);
        p0 = pulse_cnt;
        rst = 1'b1;
        send_byte(8'h3C);
        rst = 1'b0;
        chk("rst_mid.pulse",    frame_status_valid_o, 0);
        chk("rst_mid.qual",     is_preamble_or_sfd_o, 1);
        chk("rst_mid.good",     frame_good_o, 0);
        chk("rst_mid.giant",    giant_o, 0);
        chk("rst_mid.len",      frame_len_o, 0);
        chk("rst_mid.good_cnt", good_frames_o, 0);
        chk("rst_mid.bad_cnt",  bad_frames_o, 0);
        for (int i = 0; i < 10; i++) send_byte(8'h3C);
        chk("rst_mid.qual_tail", is_preamble_or_sfd_o, 1);
        chk("rst_mid.no_pulse",  pulse_cnt - p0, 0);
        end_frame("rst_mid", 0, 0, 0, 0, 1, 0, 0, 1, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_rx_frame_ctrl
`default_nettype wire
